arb_pkt_mux: RTL and testbench
==============================

# arb_pkt_mux

Requester-side companion to the round-robin arbiter `rrArbReq`. It collects packet streams from NREQ sources and drives their requests onto the arbiter's `reqBus`. It consumes the returned `grantBus` and muxes the granted source's packet onto a single output stream. At each packet end it pulses `reqArb` so the arbiter hands the bus to the next requester. It sits between the per-source packet buffers and the shared downstream link.

## Interface
- `NREQ`, default 4: number of sources; must equal the arbiter's NREQ.
- `DATA_WIDTH`, default 16: beat width in bits.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `inValid` in NREQ: per-source beat valid.
- `inData` in NREQ*DATA_WIDTH: per-source beat data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `inLast` in NREQ: per-source last beat of packet.
- `inReady` out NREQ: per-source beat accept.
- `reqBus` out NREQ: requests to the arbiter; registered.
- `reqArb` out 1: one-cycle re-arbitrate pulse to the arbiter; registered.
- `grantBus` in NREQ: grants from the arbiter; expected one-hot or zero.
- `outValid` out 1: output beat valid.
- `outData` out DATA_WIDTH: output beat data.
- `outLast` out 1: output last beat of packet.
- `outReady` in 1: downstream accept.
- `grantErr` out 1: one-cycle pulse when a grant violation is detected; registered.

## Operation
- FSM states: IDLE, XFER, RELEASE, GAP; `sel` is a log2(NREQ)-bit register holding the latched source index.
- IDLE
  - If `grantBus` is one-hot and `inValid[g]` is 1: `sel <= g`, go to XFER.
  - If `grantBus` is one-hot but `inValid[g]` is 0: stay in IDLE, no error. This covers the case where the request has dropped but the grant lags it.
  - If `grantBus` has more than one bit set: pulse `grantErr`, stay in IDLE.
  - If `grantBus` is zero: stay in IDLE.
- XFER
  - `outValid = inValid[sel]`, `outData = inData[sel]`, `outLast = inLast[sel]`. These are combinational, zero added latency.
  - `inReady[sel] = outReady`. All other `inReady` bits are 0.
  - A beat transfers when `outValid & outReady`.
  - A transferred beat with `outLast = 1` moves the FSM to RELEASE.
  - `grantBus` changing during XFER (grant lost or moved) does not change `sel`. It pulses `grantErr` once per change, and the packet continues to completion.
- RELEASE (1 cycle): `reqArb` is 1 in this cycle. `reqBus[sel]` is forced to 0. Go to GAP.
- GAP (1 cycle): `reqBus[sel]` is still forced to 0, so the arbiter sees the drop before the next IDLE sample. Go to IDLE.
- `reqBus` update, registered: `reqBus[i] <= inValid[i]` except:
  - bit `sel` is held at 1 throughout XFER, so the grant is not released when a source stalls mid-packet;
  - bit `sel` is forced to 0 in RELEASE and GAP.
- In IDLE, RELEASE and GAP: `outValid` = 0, `outLast` = 0, `outData` = 0, all `inReady` = 0.
- Reset values: state IDLE, `sel` = 0, `reqBus` = 0, `reqArb` = 0, `grantErr` = 0, `outValid` = 0, `outLast` = 0, `outData` = 0, `inReady` = 0.
- Reset mid-packet: all of the above apply at the next edge. The packet is truncated; no `outLast` is emitted for it.

## Timing
- `inValid[i]` rising at edge N gives `reqBus[i]` = 1 after edge N+1.
- Grant present at edge M (IDLE) puts the FSM in XFER after edge M. First beat can transfer in cycle M+1 if `outReady` = 1.
- Throughput in XFER: 1 beat/cycle; no bubbles inside a packet when source and sink are continuously ready.
- Fixed packet-to-packet overhead: 2 cycles (RELEASE, GAP) plus the arbiter's grant latency.
- Single-beat packet (`inLast` on the first beat) is legal: sequence XFER(1 cycle) -> RELEASE -> GAP.
- `reqArb` is high exactly 1 cycle per completed packet, and never outside RELEASE.
- A source may deassert `inValid` mid-packet: `outValid` drops, the FSM stays in XFER, and `reqBus[sel]` stays 1.

## Test plan
- Single source: `inValid` = 4'b0001, 4-beat packet, `outReady` = 1, arbiter grants 4'b0001 -> 4 consecutive output beats with data matching the input; `outLast` on beat 4; `reqArb` is a 1-cycle pulse 1 cycle after the last beat; `reqBus[0]` is 0 for 2 cycles.
- Contention: sources 0 and 2 each continuously send 3-beat packets with real `rrArbReq` (TIMEOUT_CNT_MAX=16) -> output packets alternate 0,2,0,2 with no interleaved beats.
- Backpressure: `outReady` toggles 1/0 each cycle during an 8-beat packet -> 8 beats transferred in 15 cycles; `inReady[sel]` mirrors `outReady`; no other `inReady` bit is asserted.
- Grant fault: force `grantBus` = 4'b0110 in IDLE -> `grantErr` pulses, FSM stays in IDLE, `outValid` = 0. Force a grant move 4'b0001 -> 4'b0100 mid-packet -> one `grantErr` pulse, and the packet from source 0 completes.
- Source stall: source 1 drops `inValid` for 5 cycles mid-packet -> `outValid` = 0 for those 5 cycles, `reqBus[1]` stays 1, and the packet resumes with no beats lost.
- Reset mid-packet: assert `rst` for 1 cycle at beat 2 of a 6-beat packet -> all outputs are at reset values next cycle; a new request re-arbitrates from IDLE.

Source files
------------

// File: rtl/arb_pkt_mux.sv
// arb_pkt_mux: requests the arbiter on behalf of NREQ packet sources and muxes the granted source onto one stream.
// The grant is latched per packet; RELEASE/GAP drop the owner's request so the arbiter can move on.
module arb_pkt_mux #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            inValid,
   input  logic [NREQ*DATA_WIDTH-1:0] inData,
   input  logic [NREQ-1:0]            inLast,
   output logic [NREQ-1:0]            inReady,
   output logic [NREQ-1:0]            reqBus,
   output logic                       reqArb,
   input  logic [NREQ-1:0]            grantBus,
   output logic                       outValid,
   output logic [DATA_WIDTH-1:0]      outData,
   output logic                       outLast,
   input  logic                       outReady,
   output logic                       grantErr
);
   localparam int SW = NREQ > 1 ? $clog2(NREQ) : 1;
   typedef enum logic [1:0] {IDLE, XFER, RELEASE, GAP} state_t;
   state_t                r_state, w_next;
   logic [SW-1:0]         r_sel, w_sel, w_g;
   logic [NREQ-1:0]       r_gnt, r_req, w_rdy;
   logic                  r_arb, r_err, w_xfer, w_multi, w_start, w_err;
   logic [DATA_WIDTH-1:0] w_data;
   always_comb begin
      w_g = '0;
      w_data = '0;
      w_rdy = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grantBus[i]) w_g = SW'(i);
         if (SW'(i) == r_sel) w_data = inData[i*DATA_WIDTH +: DATA_WIDTH];
      end
      w_xfer = r_state == XFER;
      w_rdy[r_sel] = w_xfer & outReady;
      outValid = w_xfer & inValid[r_sel];
      outLast = w_xfer & inLast[r_sel];
      outData = w_xfer ? w_data : '0;
      w_multi = |(grantBus & (grantBus - NREQ'(1)));
      // a one-hot grant to a source that already dropped valid is a lagging grant, not an error
      w_start = r_state == IDLE && |grantBus && !w_multi && inValid[w_g];
      w_next = w_start ? XFER :
               (w_xfer && outValid && outReady && outLast) ? RELEASE :
               r_state == RELEASE ? GAP :
               r_state == GAP ? IDLE : r_state;
      w_sel = w_start ? w_g : r_sel;
      w_err = (r_state == IDLE && w_multi) || (w_xfer && grantBus != r_gnt);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel <= '0;
         r_gnt <= '0;
         r_req <= '0;
         r_arb <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_state <= w_next;
         r_sel <= w_sel;
         r_gnt <= grantBus;
         r_arb <= w_next == RELEASE;
         r_err <= w_err;
         // owner's request is held through XFER and dropped for RELEASE and GAP
         for (int i = 0; i < NREQ; i++)
            r_req[i] <= (SW'(i) == w_sel && w_next != IDLE) ? w_next == XFER : inValid[i];
      end
   end
   assign inReady = w_rdy;
   assign reqBus = r_req;
   assign reqArb = r_arb;
   assign grantErr = r_err;
endmodule

// File: tb/tb_arb_pkt_mux.sv
// tb_arb_pkt_mux: vector table for IDLE grant decode, directed packet sequences, and a randomized
// multi-source run scored against per-source beat lists with a simple round-robin arbiter model.
module tb_arb_pkt_mux;
   localparam int N = 4, W = 16, MAXB = 32;
   logic clk = 0, rst = 1;
   logic [N-1:0] inValid, inLast, inReady, reqBus, grantBus, gn;
   logic [N*W-1:0] inData;
   logic reqArb, outValid, outLast, outReady, grantErr, last_prev;
   logic [W-1:0] outData, exp_d;
   int nchk = 0, nerr = 0;
   int k, cyc, errs, rr, s, cur, tail, narb, total_pk, total_b, done_b, pl, c;
   int len [N], ptr [N], sb [N];
   logic [W-1:0] ed [N][MAXB];
   logic el [N][MAXB];
   logic first, found;
   typedef struct { logic [N-1:0] v, g; logic err, xfer; } vec_t;
   vec_t vt [8];

   always #5 clk = ~clk;

   arb_pkt_mux #(.NREQ(N), .DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inData(inData), .inLast(inLast),
      .inReady(inReady), .reqBus(reqBus), .reqArb(reqArb), .grantBus(grantBus),
      .outValid(outValid), .outData(outData), .outLast(outLast), .outReady(outReady),
      .grantErr(grantErr));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      inValid = '0; inLast = '0; inData = '0; grantBus = '0; outReady = 1'b1;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [W-1:0] beat(input int src, input int idx);
      return W'((src << 12) | (idx & 12'hfff));
   endfunction

   task automatic set_beat(input int src, input int idx, input logic last);
      inData[src*W +: W] = beat(src, idx);
      inLast[src] = last;
   endtask

   initial begin
      vt[0] = '{4'b0001, 4'b0001, 1'b0, 1'b1};
      vt[1] = '{4'b0000, 4'b0001, 1'b0, 1'b0};
      vt[2] = '{4'b1111, 4'b0110, 1'b1, 1'b0};
      vt[3] = '{4'b1111, 4'b0000, 1'b0, 1'b0};
      vt[4] = '{4'b0100, 4'b0100, 1'b0, 1'b1};
      vt[5] = '{4'b1000, 4'b1001, 1'b1, 1'b0};
      vt[6] = '{4'b1111, 4'b1111, 1'b1, 1'b0};
      vt[7] = '{4'b0010, 4'b1000, 1'b0, 1'b0};

      // reset holds everything at rest even with live inputs
      idle_in();
      inValid = 4'b1111; grantBus = 4'b0001;
      tick(); tick();
      chk("rst_req", reqBus, 0); chk("rst_arb", reqArb, 0); chk("rst_err", grantErr, 0);
      chk("rst_ov", outValid, 0); chk("rst_ol", outLast, 0); chk("rst_od", outData, 0);
      chk("rst_rdy", inReady, 0);

      // IDLE grant decode table
      foreach (vt[j]) begin
         do_reset();
         exp_d = '0;
         for (int i = 0; i < N; i++) begin
            set_beat(i, 0, 1'b0);
            if (vt[j].g == N'(1) << i) exp_d = beat(i, 0);
         end
         inValid = vt[j].v; grantBus = vt[j].g;
         tick();
         grantBus = '0;
         #1;
         chk($sformatf("vec%0d_err", j), grantErr, vt[j].err);
         chk($sformatf("vec%0d_ov", j), outValid, vt[j].xfer);
         chk($sformatf("vec%0d_rdy", j), inReady, vt[j].xfer ? vt[j].g : '0);
         chk($sformatf("vec%0d_od", j), outData, vt[j].xfer ? exp_d : '0);
      end

      // single source, 4 beats, then RELEASE/GAP with the next packet pending
      do_reset();
      inValid = 4'b0001; set_beat(0, 0, 1'b0);
      tick();
      chk("ss_req", reqBus, 4'b0001);
      grantBus = 4'b0001;
      tick();
      for (int b = 0; b < 4; b++) begin
         set_beat(0, b, b == 3);
         #1;
         chk("ss_ov", outValid, 1); chk("ss_od", outData, beat(0, b));
         chk("ss_ol", outLast, b == 3); chk("ss_rdy", inReady, 4'b0001);
         chk("ss_arb0", reqArb, 0);
         tick();
      end
      set_beat(0, 4, 1'b0); grantBus = '0;
      #1;
      chk("ss_rel_arb", reqArb, 1); chk("ss_rel_req", reqBus[0], 0); chk("ss_rel_ov", outValid, 0);
      tick();
      chk("ss_gap_arb", reqArb, 0); chk("ss_gap_req", reqBus[0], 0); chk("ss_gap_ov", outValid, 0);
      tick();
      chk("ss_idle_req", reqBus[0], 1); chk("ss_idle_arb", reqArb, 0);

      // backpressure: outReady toggles during an 8-beat packet
      do_reset();
      inValid = 4'b1000; grantBus = 4'b1000; set_beat(3, 0, 1'b0);
      tick();
      k = 0;
      for (cyc = 0; cyc < 40 && k < 8; cyc++) begin
         outReady = cyc % 2 == 0;
         set_beat(3, k, k == 7);
         #1;
         chk("bp_rdy", inReady, outReady ? 4'b1000 : 4'b0000);
         if (outReady) begin
            chk("bp_od", outData, beat(3, k));
            k++;
         end
         tick();
      end
      chk("bp_cycles", cyc, 15); chk("bp_arb", reqArb, 1);

      // grant moves mid-packet: one error pulse, packet completes
      do_reset();
      inValid = 4'b0001; grantBus = 4'b0001; set_beat(0, 0, 1'b0);
      tick();
      k = 0; errs = 0;
      for (cyc = 0; cyc < 20 && k < 4; cyc++) begin
         if (cyc == 1) grantBus = 4'b0100;
         set_beat(0, k, k == 3);
         #1;
         errs += int'(grantErr);
         chk("gm_od", outData, beat(0, k));
         if (outValid && outReady) k++;
         tick();
      end
      errs += int'(grantErr);
      chk("gm_errs", errs, 1); chk("gm_beats", k, 4); chk("gm_arb", reqArb, 1);

      // source 1 stalls 5 cycles mid-packet
      do_reset();
      inValid = 4'b0010; grantBus = 4'b0010;
      tick();
      k = 0;
      for (cyc = 0; cyc < 30 && k < 6; cyc++) begin
         inValid[1] = !(cyc >= 2 && cyc < 7);
         set_beat(1, k, k == 5);
         #1;
         if (!inValid[1]) begin
            chk("st_ov", outValid, 0); chk("st_req", reqBus[1], 1);
         end else begin
            chk("st_ov", outValid, 1); chk("st_od", outData, beat(1, k)); chk("st_ol", outLast, k == 5);
         end
         if (outValid && outReady) k++;
         tick();
      end
      chk("st_cycles", cyc, 11); chk("st_arb", reqArb, 1);

      // reset at beat 2 of a 6-beat packet
      do_reset();
      inValid = 4'b0100; grantBus = 4'b0100; set_beat(2, 0, 1'b0);
      tick();
      for (int b = 0; b < 2; b++) begin
         set_beat(2, b, 1'b0);
         #1;
         chk("rm_od", outData, beat(2, b));
         tick();
      end
      set_beat(2, 2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rm_ov", outValid, 0); chk("rm_ol", outLast, 0); chk("rm_od0", outData, 0);
      chk("rm_rdy", inReady, 0); chk("rm_req", reqBus, 0); chk("rm_arb", reqArb, 0);
      chk("rm_err", grantErr, 0);
      set_beat(2, 0, 1'b0);
      tick();
      chk("rm_again_ov", outValid, 1); chk("rm_again_od", outData, beat(2, 0));

      // randomized contention against per-source beat lists
      do_reset();
      total_pk = 0; total_b = 0;
      for (int i = 0; i < N; i++) begin
         len[i] = 0; ptr[i] = 0; sb[i] = 0;
         for (int p = 0; p < 6; p++) begin
            pl = $urandom_range(1, 5);
            total_pk++;
            for (int b = 0; b < pl; b++) begin
               ed[i][len[i]] = beat(i, len[i]);
               el[i][len[i]] = b == pl - 1;
               len[i]++;
               total_b++;
            end
         end
      end
      cur = -1; rr = N - 1; tail = 0; narb = 0; done_b = 0; last_prev = 1'b0;
      for (cyc = 0; cyc < 4000 && tail < 3; cyc++) begin
         for (int i = 0; i < N; i++) begin
            first = ptr[i] == 0 || el[i][ptr[i] == 0 ? 0 : ptr[i] - 1];
            inValid[i] = ptr[i] < len[i] && (first || $urandom_range(0, 9) >= 3);
            inData[i*W +: W] = ptr[i] < len[i] ? ed[i][ptr[i]] : '0;
            inLast[i] = ptr[i] < len[i] ? el[i][ptr[i]] : 1'b0;
         end
         outReady = $urandom_range(0, 3) != 0;
         #1;
         chk("rnd_err", grantErr, 0);
         chk("rnd_arb", reqArb, last_prev);
         chk("rnd_rdy1", $countones(inReady) <= 1, 1);
         narb += int'(reqArb);
         last_prev = 1'b0;
         if (outValid && outReady) begin
            s = cur >= 0 ? cur : int'(outData[13:12]);
            chk("rnd_od", outData, ed[s][sb[s] < len[s] ? sb[s] : 0]);
            chk("rnd_ol", outLast, el[s][sb[s] < len[s] ? sb[s] : 0]);
            chk("rnd_src_rdy", inReady, N'(1) << s);
            sb[s]++;
            done_b++;
            cur = outLast ? -1 : s;
            last_prev = outLast;
         end
         for (int i = 0; i < N; i++) if (inValid[i] && inReady[i]) ptr[i]++;
         if (grantBus != '0) gn = (reqArb || !(|(grantBus & reqBus))) ? '0 : grantBus;
         else begin
            gn = '0; found = 1'b0;
            for (int o = 1; o <= N; o++) begin
               c = (rr + o) % N;
               if (!found && reqBus[c]) begin
                  gn = N'(1) << c; rr = c; found = 1'b1;
               end
            end
         end
         if (done_b == total_b) tail++;
         tick();
         grantBus = gn;
      end
      chk("rnd_beats", done_b, total_b);
      chk("rnd_pkts", narb, total_pk);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
